// File: rtl/fpu_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// fpu_req_arbiter_if
// Requester-side bus of the shared-fpu arbiter.
//   req_valid  [NREQ]     per-requester request, held with operands until ready
//   req_op_a/b [NREQ*32]  operands, requester i at [32*i +: 32]
//   req_ready  [NREQ]     one-hot accept pulse
//   rsp_valid  [NREQ]     one-hot response pulse (no backpressure)
//   rsp_data   [32]       fpu result of the responding op
//   rsp_status [4]        fpu status of the responding op
//   rsp_id     [IDW]      index of the responding requester
// master: requester side, slave: arbiter side.
// ----------------------------------------------------------------------------
interface fpu_req_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_op_a;
  logic [NREQ*32-1:0] req_op_b;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_data;
  logic [3:0]         rsp_status;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid, req_op_a, req_op_b,
    input  req_ready, rsp_valid, rsp_data, rsp_status, rsp_id
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b,
    output req_ready, rsp_valid, rsp_data, rsp_status, rsp_id
  );
endinterface

// File: rtl/fpu_req_arbiter.sv
// ----------------------------------------------------------------------------
// fpu_req_arbiter
// Shares one free-running fpu between NREQ requesters with round-robin
// arbitration. The fpu runs a fixed FRAME-cycle loop from reset with no
// start/done handshake, so a local phase counter mirrors that loop: ph==0 is
// the fpu operand-sampling cycle, and the result of the previous frame's
// operands is visible during ph==0.
// Ports:
//   clock100KHz    clock shared with the fpu
//   reset          async active-low reset shared with the fpu
//   bus            requester bus (slave modport)
//   fpu_op_a/b     operands driven to the fpu, stable for a whole frame
//   fpu_data_in    fpu result
//   fpu_status_in  fpu status
//   busy           an op is issued or in flight
// ----------------------------------------------------------------------------
module fpu_req_arbiter #(
  parameter int NREQ  = 2,
  parameter int FRAME = 5,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clock100KHz,
  input  logic               reset,
  fpu_req_arbiter_if.slave   bus,
  output logic [31:0]        fpu_op_a,
  output logic [31:0]        fpu_op_b,
  input  logic [31:0]        fpu_data_in,
  input  logic [3:0]         fpu_status_in,
  output logic               busy
);

  localparam int             PHW     = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [PHW-1:0] PH_LAST = PHW'(FRAME - 1);
  localparam logic [PHW-1:0] PH_ZERO = {PHW{1'b0}};
  localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [NREQ-1:0] v;
    v = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      v[i] = (IDW'(i) == id);
    end
    return v;
  endfunction

  // State
  logic [PHW-1:0]  ph_q,         ph_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic            issue_v_q,    issue_v_d;
  logic [IDW-1:0]  issue_id_q,   issue_id_d;
  logic            inflight_q,   inflight_d;
  logic [IDW-1:0]  pend_id_q,    pend_id_d;
  logic [31:0]     op_a_q,       op_a_d;
  logic [31:0]     op_b_q,       op_b_d;
  logic [NREQ-1:0] rsp_valid_q,  rsp_valid_d;
  logic [31:0]     rsp_data_q,   rsp_data_d;
  logic [3:0]      rsp_status_q, rsp_status_d;
  logic [IDW-1:0]  rsp_id_q,     rsp_id_d;

  // Combinational helpers
  logic            ph_last_s;
  logic            capture_s;
  int              dist_s;
  int              best_dist_s;
  logic            take_s;
  logic [IDW-1:0]  grant_id_s;
  logic            grant_v_s;
  logic [NREQ-1:0] ready_s;
  logic [31:0]     win_a_s;
  logic [31:0]     win_b_s;

  assign ph_last_s = (ph_q == PH_LAST);
  // Result of the frame that just ended is visible now; capture it if it was ours.
  assign capture_s = (ph_q == PH_ZERO) && inflight_q;

  // Round-robin search: the requester closest after last_grant (cyclically) wins.
  always_comb begin
    best_dist_s = NREQ;
    dist_s      = 0;
    take_s      = 1'b0;
    grant_id_s  = {IDW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      // distance 0 is last_grant+1, distance NREQ-1 is last_grant itself
      dist_s      = (i + NREQ - 1 - int'(last_grant_q)) % NREQ;
      take_s      = bus.req_valid[i] && (dist_s < best_dist_s);
      grant_id_s  = take_s ? IDW'(i) : grant_id_s;
      best_dist_s = take_s ? dist_s : best_dist_s;
    end
    grant_v_s = ph_last_s && (best_dist_s < NREQ);
    ready_s   = grant_v_s ? onehot(grant_id_s) : {NREQ{1'b0}};
  end

  // Winner operand select; index {id, 5'b0} is 32*id.
  always_comb begin
    win_a_s = bus.req_op_a[{grant_id_s, 5'b00000} +: 32];
    win_b_s = bus.req_op_b[{grant_id_s, 5'b00000} +: 32];
  end

  // Next-state: phase, issue, in-flight tracking and response capture.
  always_comb begin
    ph_d = ph_last_s ? PH_ZERO : (ph_q + PHW'(1));

    if (grant_v_s) begin
      last_grant_d = grant_id_s;
      issue_id_d   = grant_id_s;
      op_a_d       = win_a_s;
      op_b_d       = win_b_s;
    end else begin
      last_grant_d = last_grant_q;
      issue_id_d   = issue_id_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
    end

    // issue_v describes the op the fpu samples in the coming frame
    issue_v_d = ph_last_s ? grant_v_s : issue_v_q;

    // At the wrap the issued op becomes the one the fpu is working on
    if (ph_last_s) begin
      inflight_d = issue_v_q;
      pend_id_d  = issue_id_q;
    end else begin
      inflight_d = inflight_q;
      pend_id_d  = pend_id_q;
    end

    if (capture_s) begin
      rsp_valid_d  = onehot(pend_id_q);
      rsp_data_d   = fpu_data_in;
      rsp_status_d = fpu_status_in;
      rsp_id_d     = pend_id_q;
    end else begin
      rsp_valid_d  = {NREQ{1'b0}};
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      rsp_id_d     = rsp_id_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      ph_q         <= PH_ZERO;
      last_grant_q <= ID_LAST;
      issue_v_q    <= 1'b0;
      issue_id_q   <= {IDW{1'b0}};
      inflight_q   <= 1'b0;
      pend_id_q    <= {IDW{1'b0}};
      op_a_q       <= 32'h0000_0000;
      op_b_q       <= 32'h0000_0000;
      rsp_valid_q  <= {NREQ{1'b0}};
      rsp_data_q   <= 32'h0000_0000;
      rsp_status_q <= 4'b0000;
      rsp_id_q     <= {IDW{1'b0}};
    end else begin
      ph_q         <= ph_d;
      last_grant_q <= last_grant_d;
      issue_v_q    <= issue_v_d;
      issue_id_q   <= issue_id_d;
      inflight_q   <= inflight_d;
      pend_id_q    <= pend_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_id     = rsp_id_q;
  assign fpu_op_a       = op_a_q;
  assign fpu_op_b       = op_b_q;
  assign busy           = inflight_q | issue_v_q;

endmodule
